// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and defaults for the STDP spike wave controller
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } wave_state_e;

  localparam int DEF_TIME_PERIOD = 16;
  localparam int DEF_N_INPUTS    = 8;

endpackage

// File: rtl/spike_cmp_lane.sv
// rtl/spike_cmp_lane.sv - one lane of step-coded spike generation
module spike_cmp_lane #(
  parameter int TW = 4
) (
  input  logic [TW-1:0] time_i,
  input  logic [TW-1:0] spike_time_i,
  input  logic          mask_i,
  input  logic          run_en_i,
  output logic          spike_o
);

  // Once the wave time reaches the lane's spike time the output holds high until wave end.
  assign spike_o = run_en_i && !mask_i && (spike_time_i <= time_i);

endmodule

// File: rtl/spike_wave_controller.sv
// rtl/spike_wave_controller.sv - gamma wave sequencer with one-entry shadow load buffer
module spike_wave_controller
  import stdp_pkg::*;
#(
  parameter int N_INPUTS    = DEF_N_INPUTS,
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  parameter int WCW         = 16,
  localparam int TW         = $clog2(TIME_PERIOD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [N_INPUTS*TW-1:0] load_times,
  input  logic [N_INPUTS-1:0]    load_mask,
  input  logic                   abort,
  output logic [TW-1:0]          time_val,
  output logic [N_INPUTS-1:0]    spike_vec,
  output logic                   busy,
  output logic                   done,
  output logic [WCW-1:0]         wave_count
);

  localparam logic [TW-1:0] LAST_T = TW'(TIME_PERIOD - 1);

  wave_state_e             state_q;
  logic [TW-1:0]           time_q;
  logic [WCW-1:0]          wave_count_q;
  logic                    shadow_full_q;
  logic [N_INPUTS*TW-1:0]  shadow_times_q;
  logic [N_INPUTS-1:0]     shadow_mask_q;
  logic [N_INPUTS*TW-1:0]  times_act_q;
  logic [N_INPUTS-1:0]     mask_act_q;
  logic                    load_accept_d;

  assign load_ready    = !shadow_full_q;
  assign load_accept_d = load_valid && !shadow_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      time_q         <= '0;
      wave_count_q   <= '0;
      shadow_full_q  <= 1'b0;
      shadow_times_q <= '0;
      shadow_mask_q  <= '0;
      times_act_q    <= '0;
      mask_act_q     <= '1;
    end else begin
      // A load can never coincide with a transfer: load_ready is low whenever the shadow is full.
      if (load_accept_d) begin
        shadow_times_q <= load_times;
        shadow_mask_q  <= load_mask;
        shadow_full_q  <= 1'b1;
      end
      if (abort) begin
        state_q    <= ST_IDLE;
        time_q     <= '0;
        mask_act_q <= '1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (shadow_full_q) begin
              times_act_q   <= shadow_times_q;
              mask_act_q    <= shadow_mask_q;
              shadow_full_q <= 1'b0;
              time_q        <= '0;
              state_q       <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (time_q == LAST_T) begin
              time_q  <= '0;
              state_q <= ST_GAP;
            end else begin
              time_q <= time_q + TW'(1);
            end
          end
          ST_GAP: begin
            wave_count_q <= wave_count_q + WCW'(1);
            time_q       <= '0;
            if (shadow_full_q) begin
              times_act_q   <= shadow_times_q;
              mask_act_q    <= shadow_mask_q;
              shadow_full_q <= 1'b0;
              state_q       <= ST_RUN;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            time_q  <= '0;
          end
        endcase
      end
    end
  end

  assign time_val   = time_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign done       = (state_q == ST_GAP) && !abort;
  assign wave_count = wave_count_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
      spike_cmp_lane #(
        .TW(TW)
      ) u_lane (
        .time_i      (time_q),
        .spike_time_i(times_act_q[gi*TW +: TW]),
        .mask_i      (mask_act_q[gi]),
        .run_en_i    (state_q == ST_RUN),
        .spike_o     (spike_vec[gi])
      );
    end
  endgenerate

endmodule

// File: doc/spike_wave_controller.md
# spike_wave_controller

Sequences temporal-coded input spike generation for the clocked STDP column, one gamma wave at a time. Accepts a per-input vector of spike times plus a per-input inhibit mask, then sweeps a time counter across the wave and drives a step-coded spike vector. An input goes high at its spike time and holds until wave end. A one-entry shadow buffer allows the next wave to be loaded during the current one, so waves run back-to-back with exactly one gamma-reset gap cycle between them.

## Interface
Parameters:
- N_INPUTS, 8, number of spike lanes
- TIME_PERIOD, 16, RUN cycles per wave; must be a power of 2, ≥2
- TW, $clog2(TIME_PERIOD), time/spike-time width (derived, not overridden)
- WCW, 16, wave counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- load_valid  in  1  load_times/load_mask valid
- load_ready  out  1  shadow buffer empty; equals !shadow_full
- load_times  in  N_INPUTS*TW  lane i spike time at bits [i*TW +: TW]
- load_mask  in  N_INPUTS  1 = lane i suppressed for this wave
- abort  in  1  synchronous cancel of current wave
- time_val  out  TW  current wave time step
- spike_vec  out  N_INPUTS  lane spike outputs
- busy  out  1  state is RUN or GAP
- done  out  1  one-cycle pulse in the GAP cycle of a completed wave
- wave_count  out  WCW  completed waves, wraps modulo 2^WCW

## Operation
- Load is accepted on a cycle with load_valid && load_ready. Times and mask are captured into the shadow registers, and shadow_full is set.
- States:
  - IDLE: if shadow_full, transfer shadow → active regs, clear shadow_full, time_val←0, go to RUN. Otherwise stay.
  - RUN: time_val increments each cycle. When time_val == TIME_PERIOD-1, go to GAP and set time_val←0.
  - GAP: done=1 and wave_count increments. If shadow_full, transfer and go to RUN. Otherwise go to IDLE.
- spike_vec[i] = (state==RUN) && !mask_act[i] && (times_act[i] <= time_val), unsigned compare. Combinational from registered state.
- spike_vec is 0 in IDLE and GAP. This is the gamma reset seen by downstream neurons.
- A spike time of 0 fires in the first RUN cycle. A spike time of TIME_PERIOD-1 fires only in the last RUN cycle.
- abort (any state): next state IDLE, time_val←0, active regs invalidated, no done pulse, wave_count unchanged.
  - The shadow buffer is preserved, so a queued wave starts from IDLE on the following cycle.
  - A load handshake in the abort cycle is honoured.
- Load during a transfer cycle cannot occur, because load_ready is 0 while shadow_full. load_ready rises the cycle after the transfer.
- Priority: rst_n > abort > normal transitions.

## Timing
- Reset values: time_val 0, spike_vec 0, busy 0, done 0, wave_count 0, load_ready 1, shadow_full 0, state IDLE.
- Load accepted in IDLE at cycle t: RUN begins at t+2 (shadow write at t, transfer at t+1, RUN at t+2). time_val=0 at t+2.
- Wave duration: TIME_PERIOD RUN cycles plus 1 GAP cycle. Back-to-back wave period is TIME_PERIOD+1 cycles.
- done is asserted during the GAP cycle only. wave_count shows the new value the cycle after done.
- Output latency: spike_vec follows time_val within the same cycle; there is no extra register stage.

## Structure
- Shared package stdp_pkg holds:
  - the state enum type (IDLE, RUN, GAP)
  - default TIME_PERIOD and N_INPUTS localparams
- Sub-module spike_cmp_lane implements one lane's gated compare. Inputs are time, spike time, mask and run enable; output is the spike bit. It is instantiated N_INPUTS times in a generate loop.
- Top level holds the FSM, time counter, and shadow and active registers.

## Test plan
- Single wave: after reset, load times {0,3,15,7,…} with mask 0. Required:
  - lane0 high from time_val 0
  - lane1 high from 3
  - lane2 high only at 15
  - all lanes low in GAP
  - done for 1 cycle; wave_count=1
- Mask: load time 0 with mask[4]=1. Required: lane4 stays 0 for the whole wave while the other lanes fire.
- Back-to-back: load wave B during wave A's RUN. Required:
  - load_ready drops
  - after A's GAP, RUN restarts at time_val 0 with no IDLE cycle
  - period is 17 cycles at TIME_PERIOD=16
- Abort at time_val 5 with shadow full. Required:
  - no done pulse
  - wave_count unchanged
  - IDLE for 1 cycle, then the queued wave starts
- Reset mid-RUN, with rst_n low for 1 cycle. Required: all outputs return to reset values and the shadow is cleared (load_ready=1).
- Wrap: force 2^WCW completed waves, or use WCW=2 (4 waves). Required: wave_count wraps to 0.
